// File: rtl/gate_truth_table_sequencer.sv
// gate_truth_table_sequencer: steps a two-input gate through all four input vectors,
// captures its truth table and compares it against a latched expected table.
module gate_truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       I1,
    output logic       I2,
    input  logic       O,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_out,
    output logic [3:0] mismatch,
    output logic       pass
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0] exp_q;
    logic [3:0] final_tbl;
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 2**CNT_W - 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must lie in 1..2**CNT_W-1");
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? SETTLE : IDLE;
            SETTLE:     state_nx = (cnt == '0) ? SAMPLE : SETTLE;
            SAMPLE:     state_nx = (idx == 2'd3) ? DONE : SETTLE;
            default:    state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
    end
    // final compare folds in the O bit being captured on this same edge
    assign final_tbl = {O, table_out[2:0]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {I1, I2}  <= 2'b00;
            table_out <= '0;
            mismatch  <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            exp_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    {I1, I2} <= 2'b00;
                    if (start) begin
                        exp_q     <= expected;
                        table_out <= '0;
                        mismatch  <= '0;
                        pass      <= 1'b0;
                        idx       <= '0;
                        cnt       <= CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                SAMPLE: begin
                    table_out[idx] <= O;
                    if (idx == 2'd3) begin
                        {I1, I2} <= 2'b00;
                        mismatch <= final_tbl ^ exp_q;
                        pass     <= (final_tbl == exp_q);
                    end else begin
                        idx      <= idx + 2'd1;
                        {I1, I2} <= idx + 2'd1;
                        cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
